// File: rtl/iir_csa_sched_pkg.sv
// Shared types and constants for the carry-save IIR subtractor scheduler.
package iir_csa_sched_pkg;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_N_CH      = 4;
  localparam int CSA_SUB_CONST = 3;

  typedef logic [$clog2(DEF_N_CH)-1:0] ch_idx_t;
endpackage

// File: rtl/iir_csa_sched_csa.sv
// Bitwise 3:2 carry-save compressor; carry_o is unshifted (weight 2 per bit).
module iir_csa_sched_csa #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);
  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/iir_csa_sched.sv
// Round-robin scheduler sharing one carry-save y[n] = x[n] - y[n-1] slice
// between N_CH channels, with a single registered, backpressured output.
module iir_csa_sched
  import iir_csa_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_CH  = DEF_N_CH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           req_valid,
  input  logic [N_CH*WIDTH-1:0]     req_sample,
  output logic [N_CH-1:0]           req_ready,
  input  logic [N_CH-1:0]           clr,
  output logic                      out_valid,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready
);
  localparam int CHW = $clog2(N_CH);

  logic [WIDTH-1:0] sum_q   [N_CH];
  logic [WIDTH-1:0] carry_q [N_CH];
  logic [CHW-1:0]   rr_q, rr_d;
  logic             out_valid_q, out_valid_d;
  logic [CHW-1:0]   out_ch_q, out_ch_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             out_free;
  logic [N_CH-1:0]  elig;
  logic             grant_found;
  logic [CHW-1:0]   grant_idx;

  logic [WIDTH-1:0] x_sel, sum_sel, carry_sel, ncarry_sh;
  logic [WIDTH-1:0] s1_sum, s1_carry, s1_carry_sh;
  logic [WIDTH-1:0] s2_sum, s2_carry, resolved;

  // Scan downward so the lowest offset from start is the last (winning) hit.
  function automatic logic [CHW:0] rr_pick(input logic [N_CH-1:0] e,
                                           input logic [CHW-1:0] start);
    logic [CHW:0] res;
    int           idx;
    res = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_CH;
      if (e[idx]) res = {1'b1, idx[CHW-1:0]};
    end
    return res;
  endfunction

  assign out_free = !out_valid_q || out_ready;
  assign elig     = req_valid & ~clr & {N_CH{out_free}};

  always_comb begin
    {grant_found, grant_idx} = rr_pick(elig, rr_q);
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
    assign req_ready[gi] = grant_found && (grant_idx == CHW'(gi));
  end

  assign x_sel     = req_sample[int'(grant_idx)*WIDTH +: WIDTH];
  assign sum_sel   = sum_q[grant_idx];
  assign carry_sel = carry_q[grant_idx];

  // x + ~s + 2*~c = x - y_prev - 3; the second stage adds the 3 back.
  assign ncarry_sh = (~carry_sel) << 1;

  iir_csa_sched_csa #(.WIDTH(WIDTH)) u_csa_s1 (
    .a_i    (x_sel),
    .b_i    (~sum_sel),
    .c_i    (ncarry_sh),
    .sum_o  (s1_sum),
    .carry_o(s1_carry)
  );

  assign s1_carry_sh = s1_carry << 1;

  iir_csa_sched_csa #(.WIDTH(WIDTH)) u_csa_s2 (
    .a_i    (WIDTH'(CSA_SUB_CONST)),
    .b_i    (s1_sum),
    .c_i    (s1_carry_sh),
    .sum_o  (s2_sum),
    .carry_o(s2_carry)
  );

  assign resolved = s2_sum + (s2_carry << 1);

  always_comb begin
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    if (grant_found) begin
      rr_d        = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + CHW'(1);
      out_valid_d = 1'b1;
      out_ch_d    = grant_idx;
      out_data_d  = resolved;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  // A cleared channel is never granted, so clear and update cannot collide.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst || clr[i]) begin
        sum_q[i]   <= '0;
        carry_q[i] <= '0;
      end else if (grant_found && grant_idx == CHW'(i)) begin
        sum_q[i]   <= s2_sum;
        carry_q[i] <= s2_carry;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_iir_csa_sched.sv
// Directed bench for iir_csa_sched with a per-channel y_prev reference model.
module tb_iir_csa_sched;
  import iir_csa_sched_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_sample = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    clr = '0;
  logic            out_valid;
  ch_idx_t         out_ch;
  logic [W-1:0]    out_data;
  logic            out_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  iir_csa_sched #(.WIDTH(W), .N_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sample(req_sample),
    .req_ready (req_ready),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: y_prev per channel, arithmetic level
  logic [W-1:0] m_y [N];
  int           m_rr;
  logic         m_valid;
  int           m_ch;
  logic [W-1:0] m_data;
  bit           m_ok = 0;

  function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] c,
                              input bit free, input int start);
    if (!free) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (v[i] && !c[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] samp(input int ch);
    return req_sample[ch*W +: W];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_y[i] = '0;
      m_rr = 0; m_valid = 0; m_ch = 0; m_data = '0; m_ok = 1;
    end else if (m_ok) begin
      int g;
      g = pick(req_valid, clr, !m_valid || out_ready, m_rr);
      for (int i = 0; i < N; i++) if (clr[i]) m_y[i] = '0;
      if (g >= 0) begin
        m_data  = samp(g) - m_y[g];
        m_y[g]  = m_data;
        m_ch    = g;
        m_valid = 1;
        m_rr    = (g + 1) % N;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok && !rst) begin
      int g;
      logic [N-1:0] exp_rdy;
      g = pick(req_valid, clr, !m_valid || out_ready, m_rr);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("model_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      chk("model_out_ch",    32'(out_ch),    32'(m_ch));
      chk("model_out_data",  32'(out_data),  32'(m_data));
      $display("cyc t=%0t rdy=%b ov=%0d ch=%0d data=0x%04h", $time, req_ready, out_valid, out_ch, out_data);
    end
  end

  // ---------------- directed stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int ch, input logic [W-1:0] v);
    req_sample[ch*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; clr = '0; out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send(input int ch, input logic [W-1:0] v);
    req_valid = '0; req_valid[ch] = 1'b1; set_x(ch, v);
    step();
    req_valid = '0;
  endtask

  initial begin
    logic [W-1:0] exp_d [6];
    int           exp_c [6];

    // Reset values and a two-sample sequence on channel 0
    do_reset(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    send(0, 16'd5);
    chk("ch0_first_data", 32'(out_data), 32'h0005);
    chk("ch0_first_ch",   32'(out_ch),   32'd0);
    send(0, 16'd3);
    chk("ch0_second_data", 32'(out_data), 32'hFFFE);
    chk("ch0_second_ch",   32'(out_ch),   32'd0);
    step();

    // Round-robin with all channels requesting
    do_reset();
    for (int i = 0; i < N; i++) set_x(i, 16'(i + 1));
    exp_c = '{0, 1, 2, 3, 0, 1};
    exp_d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0};
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_out_valid", 32'(out_valid), 32'd1);
      chk("rr_out_ch",    32'(out_ch),    32'(exp_c[k]));
      chk("rr_out_data",  32'(out_data),  32'(exp_d[k]));
    end
    req_valid = '0; step();

    // Stall with requests pending
    do_reset();
    send(1, 16'h0042);
    out_ready = 1'b0; req_valid = '1;
    for (int i = 0; i < N; i++) set_x(i, 16'h0011);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      step();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data",  32'(out_data),  32'h0042);
    end
    out_ready = 1'b1; #1;
    chk("release_req_ready", 32'(req_ready), 32'b0100);
    step();
    chk("release_out_ch", 32'(out_ch), 32'd2);
    req_valid = '0;
    send(1, 16'h0050);
    chk("stall_state_kept", 32'(out_data), 32'h000E);
    step();

    // Clear collides with a request
    do_reset();
    send(2, 16'h0010);
    chk("clr_setup", 32'(out_data), 32'h0010);
    req_valid = 4'b0100; set_x(2, 16'd7); clr = 4'b0100; #1;
    chk("clr_no_grant", 32'(req_ready), 32'd0);
    step();
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    clr = '0;
    step();
    chk("clr_after_data", 32'(out_data), 32'h0007);
    req_valid = '0; step();

    // Modular wrap on channel 3
    do_reset();
    send(3, 16'h0001);
    send(3, 16'h0000);
    chk("wrap_ffff", 32'(out_data), 32'hFFFF);
    send(3, 16'h8000);
    chk("wrap_8001", 32'(out_data), 32'h8001);
    step();

    // Reset mid-stream
    do_reset();
    send(1, 16'd4);
    req_valid = 4'b0001; set_x(0, 16'd2);
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; req_valid = '1; #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_rr",    32'(req_ready), 32'b0001);
    req_valid = '0;
    send(1, 16'd9);
    chk("post_rst_data", 32'(out_data), 32'h0009);
    chk("post_rst_ch",   32'(out_ch),   32'd1);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
